// File: rtl/definitions_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Word types, text-region bounds, fetch-entry bundle, FSM state enum.
package definitions_pkg;

    typedef logic [31:0] word_ut;
    typedef logic [31:0] word_32ut;

    localparam int FETCH_DEPTH_DEFAULT = 2;

    localparam word_ut TEXT_ORG = 32'h0000_0100;
    localparam word_ut TEXT_END = 32'h0000_0200;

    typedef struct packed {
        word_32ut instr;
        word_ut   pc;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    // Sequential fetch address; the text region is treated as a ring.
    function automatic word_ut next_fpc(input word_ut pc);
        word_ut inc;
        inc = pc + 32'd4;
        return (inc == TEXT_END) ? TEXT_ORG : inc;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// master: valid/instr/pc out, ready in; slave: the reverse.
interface fetch_if;
    import definitions_pkg::*;

    logic     valid;
    logic     ready;
    word_32ut instr;
    word_ut   pc;

    modport master (output valid, output instr, output pc, input ready);
    modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry ring with push/pop/flush, full/empty.
// Ports: clk_i, rst_ni, push_i, push_data_i, flush_i, full_o, empty_o, out (fetch_if.master).
module fetch_fifo
    import definitions_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    fetch_if.master      out
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];
    logic          pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign pop       = out.valid & out.ready;
    assign out.valid = ~empty_o;
    assign out.instr = mem_q[rd_q].instr;
    assign out.pc    = mem_q[rd_q].pc;

    // Pointers are AW bits wide, so a power-of-two depth wraps for free.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop)    rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: fetch pointer, redirect/fault FSM, prefetch buffer.
// Ports: clk_i, rst_ni, instr_a_o/instr_i (imem), redirect_i/redirect_pc_i,
// fetch_valid_o/fetch_ready_i/fetch_instr_o/fetch_pc_o (decode), fetch_fault_o.
// Optional: FETCH_MISALIGN_CHECK_EN enables the misaligned-redirect FAULT state.
module instr_fetch_unit
    import definitions_pkg::*;
#(
    parameter int FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    output word_ut   instr_a_o,
    input  word_32ut instr_i,
    input  logic     redirect_i,
    input  word_ut   redirect_pc_i,
    output logic     fetch_valid_o,
    input  logic     fetch_ready_i,
    output word_32ut fetch_instr_o,
    output word_ut   fetch_pc_o,
    output logic     fetch_fault_o
);

    word_ut       fpc_q, fpc_d;
    word_ut       tgt;
    logic         run;
    logic         push, pop, full, empty;
    fetch_entry_t entry;

    fetch_if fb ();

    assign fb.ready      = fetch_ready_i;
    assign fetch_valid_o = fb.valid;
    assign fetch_instr_o = fb.instr;
    assign fetch_pc_o    = fb.pc;
    assign instr_a_o     = fpc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_state_e state_q, state_d;
    assign run           = (state_q == ST_RUN);
    assign fetch_fault_o = (state_q == ST_FAULT);
`else
    assign run           = 1'b1;
    assign fetch_fault_o = 1'b0;
`endif

    // A full buffer may still fetch when the head leaves this cycle.
    assign pop   = fb.valid & fb.ready;
    assign push  = run & ~redirect_i & (~full | pop);
    assign entry = '{instr: instr_i, pc: fpc_q};

    always_comb begin
        tgt = redirect_pc_i;
`ifndef FETCH_MISALIGN_CHECK_EN
        tgt[1:0] = 2'b00;
`endif
        fpc_d = fpc_q;
        if (redirect_i)
            fpc_d = tgt;
        else if (push)
            fpc_d = next_fpc(fpc_q);
`ifdef FETCH_MISALIGN_CHECK_EN
        state_d = state_q;
        if (redirect_i)
            state_d = (|tgt[1:0]) ? ST_FAULT : ST_RUN;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpc_q   <= TEXT_ORG;
`ifdef FETCH_MISALIGN_CHECK_EN
            state_q <= ST_RUN;
`endif
        end else begin
            fpc_q   <= fpc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            state_q <= state_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (entry),
        .flush_i     (redirect_i),
        .full_o      (full),
        .empty_o     (empty),
        .out         (fb)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit (FETCH_DEPTH = 2).
// Stimulus queues expected PCs; a negedge monitor checks every accepted entry.
module tb_instr_fetch_unit;
    import definitions_pkg::*;

    localparam word_ut KEY = 32'h5A5A_0000;

    logic     clk = 1'b0;
    logic     rst_ni = 1'b0;
    word_ut   instr_a;
    word_32ut instr;
    logic     redirect = 1'b0;
    word_ut   redirect_pc = '0;
    logic     fault;

    fetch_if bus ();

    int     n_cmp = 0;
    int     n_bad = 0;
    word_ut exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory: a fixed function of the address.
    assign instr = instr_a ^ KEY;

    instr_fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .instr_a_o     (instr_a),
        .instr_i       (instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_valid_o (bus.valid),
        .fetch_ready_i (bus.ready),
        .fetch_instr_o (bus.instr),
        .fetch_pc_o    (bus.pc),
        .fetch_fault_o (fault)
    );

    task automatic chk(input string nm, input word_ut act, input word_ut exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
            exp_q.delete();
        end
        bus.ready = 1'b0;
    endtask

    always @(negedge clk) begin
        word_ut e;
        if (rst_ni && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_accept: got pc %h want none", bus.pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.pc, e);
                chk("sb_instr", bus.instr, e ^ KEY);
            end
        end
    end

    initial begin
        bus.ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_fpc", instr_a, TEXT_ORG);

        // Release, decode stalled: fills to 2, fpc stops at ORG+8
        tick();
        rst_ni = 1'b1;
        chk("pre_first_valid", 32'(bus.valid), 32'd0);
        tick();
        chk("first_valid", 32'(bus.valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_head_pc", bus.pc, TEXT_ORG);
        end
        chk("stall_head_instr", bus.instr, TEXT_ORG ^ KEY);
        chk("stall_fpc", instr_a, TEXT_ORG + 32'h8);

        // Redirect while full: old entries must never appear
        redirect = 1'b1;
        redirect_pc = TEXT_ORG + 32'h40;
        tick();
        redirect = 1'b0;
        chk("flush_valid", 32'(bus.valid), 32'd0);
        chk("redir_fpc", instr_a, TEXT_ORG + 32'h40);
        exp_q.push_back(TEXT_ORG + 32'h40);
        exp_q.push_back(TEXT_ORG + 32'h44);
        exp_q.push_back(TEXT_ORG + 32'h48);
        bus.ready = 1'b1;
        drain();

        // Redirect with a same-cycle pop: head 0x14C counts as accepted
        tick();
        tick();
        exp_q.push_back(TEXT_ORG + 32'h4C);
        exp_q.push_back(TEXT_ORG + 32'h80);
        exp_q.push_back(TEXT_ORG + 32'h84);
        redirect = 1'b1;
        redirect_pc = TEXT_ORG + 32'h80;
        bus.ready = 1'b1;
        tick();
        redirect = 1'b0;
        drain();

        // Wrap at the end of the text region
        redirect = 1'b1;
        redirect_pc = TEXT_END - 32'h8;
        tick();
        redirect = 1'b0;
        exp_q.push_back(TEXT_END - 32'h8);
        exp_q.push_back(TEXT_END - 32'h4);
        exp_q.push_back(TEXT_ORG);
        exp_q.push_back(TEXT_ORG + 32'h4);
        bus.ready = 1'b1;
        drain();

        // Misaligned redirect
        redirect = 1'b1;
        redirect_pc = TEXT_ORG + 32'h42;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("fault_flag", 32'(fault), 32'd1);
            chk("fault_valid", 32'(bus.valid), 32'd0);
            tick();
        end
        exp_q.push_back(TEXT_ORG + 32'h80);
        exp_q.push_back(TEXT_ORG + 32'h84);
        redirect = 1'b1;
        redirect_pc = TEXT_ORG + 32'h80;
        tick();
        redirect = 1'b0;
        chk("fault_clear", 32'(fault), 32'd0);
        drain();
`else
        chk("nofault_flag", 32'(fault), 32'd0);
        chk("nofault_fpc", instr_a, TEXT_ORG + 32'h40);
        exp_q.push_back(TEXT_ORG + 32'h40);
        exp_q.push_back(TEXT_ORG + 32'h44);
        bus.ready = 1'b1;
        drain();
`endif

        // Asynchronous reset pulse mid-stream, no clock edge
        tick();
        tick();
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_valid", 32'(bus.valid), 32'd0);
        chk("async_pc", bus.pc, 32'd0);
        chk("async_fpc", instr_a, TEXT_ORG);
        #1;
        rst_ni = 1'b1;
        exp_q.push_back(TEXT_ORG);
        exp_q.push_back(TEXT_ORG + 32'h4);
        exp_q.push_back(TEXT_ORG + 32'h8);
        bus.ready = 1'b1;
        chk("restart_empty", 32'(bus.valid), 32'd0);
        drain();
        chk("end_fault", 32'(fault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
